// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the memory-port arbiter.
// Consumers: mem_port_arbiter (top) and rr_picker.
package mem_port_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_TIMEOUT  = 255;

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Combinational round-robin search: the first set req bit at or above
// (last_winner+1) mod CHANNELS, wrapping around.
module rr_picker
    import mem_port_arbiter_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_BITS = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_BITS-1:0] last_winner,
    output logic                found,
    output logic [SEL_BITS-1:0] winner
);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        // Offset CHANNELS wraps back to last_winner itself, so it is checked last.
        for (int k = 1; k <= CHANNELS; k++) begin
            if (!found && req[(int'(last_winner) + k) % CHANNELS]) begin
                found  = 1'b1;
                winner = SEL_BITS'((int'(last_winner) + k) % CHANNELS);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one requester at a time to a shared memory port.
// Optional forced release after TIMEOUT grant cycles: define MEM_PORT_ARBITER_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_BITS = $clog2(CHANNELS),
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                done,
    output logic [CHANNELS-1:0] gnt,
    output logic [SEL_BITS-1:0] sel,
    output logic                busy,
    output logic                timeout
);

    arb_state_t          state;
    logic [SEL_BITS-1:0] last_winner;
    logic [CHANNELS-1:0] cand;
    logic [CHANNELS-1:0] nxt_gnt;
    logic                found;
    logic [SEL_BITS-1:0] win;
    logic                force_rel;

    // While granted, the current owner is masked so that a lone re-request
    // passes through IDLE and receives a fresh grant.
    always_comb begin
        cand = req;
        if (state == ARB_GRANT) begin
            cand = req & ~gnt;
        end
    end

    rr_picker #(
        .CHANNELS    (CHANNELS),
        .SEL_BITS    (SEL_BITS)
    ) u_picker (
        .req         (cand),
        .last_winner (last_winner),
        .found       (found),
        .winner      (win)
    );

    always_comb begin
        nxt_gnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            nxt_gnt[i] = (win == SEL_BITS'(i));
        end
    end

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // tmo_cnt is 0 during the first grant cycle, so the grant is held TIMEOUT cycles.
    assign force_rel = !done && (tmo_cnt == 8'(TIMEOUT - 1));
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ARB_IDLE;
            gnt         <= '0;
            sel         <= '0;
            busy        <= 1'b0;
            last_winner <= SEL_BITS'(CHANNELS - 1);
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
            tmo_cnt     <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state)
                ARB_IDLE: begin
                    if (found) begin
                        state       <= ARB_GRANT;
                        gnt         <= nxt_gnt;
                        sel         <= win;
                        busy        <= 1'b1;
                        last_winner <= win;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
                        tmo_cnt     <= '0;
`endif
                    end
                end
                ARB_GRANT: begin
                    if (done || force_rel) begin
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
                        timeout <= force_rel;
`endif
                        if (found) begin
                            gnt         <= nxt_gnt;
                            sel         <= win;
                            last_winner <= win;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
                            tmo_cnt     <= '0;
`endif
                        end else begin
                            // sel keeps its value so the downstream mux output stays put.
                            state <= ARB_IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
                    else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed table, multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int CH  = 4;
    localparam int TMO = 4;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    localparam bit TE = 1'b1;
`else
    localparam bit TE = 1'b0;
`endif

    logic          clock;
    logic          reset_n;
    logic [CH-1:0] req;
    logic          done;
    logic [CH-1:0] gnt;
    logic [1:0]    sel;
    logic          busy;
    logic          timeout;

    int vectors     = 0;
    int miscompares = 0;

    mem_port_arbiter #(
        .CHANNELS (CH),
        .TIMEOUT  (TMO)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .done     (done),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .timeout  (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: who owns the port, who won last, how long it has held.
    int m_busy, m_owner, m_last, m_sel, m_held, m_tmo;

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last = CH - 1; m_sel = 0; m_held = 0; m_tmo = 0;
    endtask

    function automatic int pick(input logic [CH-1:0] m, input int last);
        for (int k = 1; k <= CH; k++) begin
            if (m[(last + k) % CH]) return (last + k) % CH;
        end
        return -1;
    endfunction

    task automatic model_grant(input int w);
        m_busy = 1; m_owner = w; m_sel = w; m_last = w; m_held = 1;
    endtask

    task automatic model_edge(input logic [CH-1:0] r, input logic d);
        logic [CH-1:0] mask;
        int w;
        bit rel;
        m_tmo = 0;
        if (m_busy == 0) begin
            if (r != 0) model_grant(pick(r, m_last));
        end else begin
            rel = 0;
            if (d) rel = 1;
            else if (TE && m_held == TMO) begin rel = 1; m_tmo = 1; end
            else m_held++;
            if (rel) begin
                mask = r;
                mask[m_owner] = 1'b0;
                w = pick(mask, m_last);
                if (w >= 0) model_grant(w);
                else m_busy = 0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        logic [CH-1:0] eg;
        eg = '0;
        if (m_busy != 0) eg[m_owner] = 1'b1;
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_sel"}, 32'(sel), 32'(m_sel));
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "_timeout"}, 32'(timeout), 32'(m_tmo));
    endtask

    // Drive inputs, advance one edge, update the model, sample 1 time unit later.
    task automatic step(input logic [CH-1:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clock);
        model_edge(r, d);
        #1;
    endtask

    typedef struct {
        logic [CH-1:0] req;
        logic          done;
        logic [CH-1:0] gnt;
        logic [1:0]    sel;
        logic          busy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // Hand-derived sequence from reset: basic grants, hold, lone re-request.
        tbl[0]  = '{4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[1]  = '{4'b0101, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[2]  = '{4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0};
        tbl[3]  = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[4]  = '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[5]  = '{4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0};
        tbl[7]  = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
        tbl[8]  = '{4'b1000, 1'b1, 4'b0000, 2'd3, 1'b0};
        tbl[9]  = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 2'd3, 1'b0};

        reset_n = 1'b0;
        req     = '0;
        done    = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].req, tbl[i].done);
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
        end

        // All channels requesting, done every third cycle: strict rotation, never idle.
        step(4'b1111, 1'b0);
        chk("rot0_gnt", 32'(gnt), 32'h1);
        for (int g = 1; g <= 4; g++) begin
            for (int c = 0; c < 2; c++) begin
                step(4'b1111, 1'b0);
                chk("rot_hold_busy", 32'(busy), 32'h1);
                chk("rot_hold_gnt", 32'(gnt), 32'(1 << ((g - 1) % 4)));
            end
            step(4'b1111, 1'b1);
            chk($sformatf("rot%0d_gnt", g), 32'(gnt), 32'(1 << (g % 4)));
            chk($sformatf("rot%0d_sel", g), 32'(sel), 32'(g % 4));
            chk("rot_busy", 32'(busy), 32'h1);
        end

        // Long hold without done: forced release only when the timeout feature is built.
        step(4'b0011, 1'b1);
        chk("hold_start_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < 100; i++) begin
            step(4'b0011, 1'b0);
            check_model("hold");
            if (!TE) chk("hold_gnt_stable", 32'(gnt), 32'h2);
        end

        // Asynchronous reset between edges while a grant is held.
        step(4'b1111, 1'b1);
        chk("prereset_busy", 32'(busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_sel", 32'(sel), 32'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        step(4'b1111, 1'b0);
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        check_model("post_rst");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter CHANNELS, default 4: number of requesters sharing the port, legal range 2..8.
REQ-002 Parameter SEL_BITS, default $clog2(CHANNELS): width of the select output.
REQ-003 Parameter TIMEOUT, default 255: grant cycle limit, legal range 2..255; used only with MEM_PORT_ARBITER_TIMEOUT_EN.
REQ-004 Port clock  in  1: single clock; all state updates on its rising edge.
REQ-005 Port reset_n  in  1: reset, asynchronous assertion, active-low.
REQ-006 Port req  in  CHANNELS: level request, bit i from requester i.
REQ-007 Port done  in  1: one-cycle pulse from the shared resource; ends the current transaction.
REQ-008 Port gnt  out  CHANNELS: registered one-hot grant; all-zero when idle.
REQ-009 Port sel  out  SEL_BITS: registered index of the granted channel; drives the downstream multiplexer sel.
REQ-010 Port busy  out  1: high while any grant is held.
REQ-011 Port timeout  out  1: one-cycle pulse on forced release; tied 0 when the feature is compiled out.

Function
REQ-012 The block SHALL implement two states: IDLE (gnt=0, busy=0) and GRANT (gnt one-hot, busy=1).
REQ-013 IDLE -> GRANT: at the edge where req is nonzero; the winner is registered into gnt and sel; first grant latency is 1 cycle after req rises.
REQ-014 Winner selection: round-robin; the first set req bit searching upward from (last_winner+1) mod CHANNELS with wrap-around.
REQ-015 last_winner SHALL update only when a grant is issued.
REQ-016 In GRANT, gnt and sel SHALL hold stable, ignoring req changes, until done or a forced release.
REQ-017 On done in GRANT with req (current winner's bit masked out) nonzero: re-arbitrate on the same edge; new grant back-to-back, no idle cycle.
REQ-018 On done in GRANT with no other req: the block SHALL go to IDLE.
REQ-019 If the current winner alone still requests at done, the block SHALL go to IDLE for one cycle, then re-grant it; this guarantees each transaction a fresh grant.
REQ-020 done while in IDLE SHALL be ignored.
REQ-021 sel SHALL retain its last value in IDLE so that the multiplexer output stays stable; gnt and busy drop to 0.

Reset
REQ-022 Asserting reset_n low SHALL, asynchronously: state=IDLE, gnt=0, sel=0, busy=0, timeout=0, last_winner=CHANNELS-1 (first grant favours channel 0), timeout counter=0.
REQ-023 Reset during GRANT SHALL abort the grant immediately with no done required.
REQ-024 The first arbitration SHALL occur at the first edge after reset_n deasserts.

Configuration
REQ-025 Macro MEM_PORT_ARBITER_TIMEOUT_EN defined: an 8-bit counter SHALL count GRANT cycles without done.
REQ-026 With the macro, when the counter reaches TIMEOUT: the grant is force-released, timeout pulses 1 cycle, and re-arbitration follows REQ-017/018; the counter clears on every new grant.
REQ-027 Macro undefined: no counter is built, timeout is constant 0, and a grant is held indefinitely until done.

Structure
REQ-028 The shared package SHALL hold the state enum (ARB_IDLE, ARB_GRANT) and the default CHANNELS and TIMEOUT constants.
REQ-029 Sub-module rr_picker SHALL be combinational: inputs req and last_winner; outputs a found flag and the winner index.
REQ-030 The multiplexer SHALL be instantiated by the parent, not inside this block.

Verification
REQ-031 Reset, then req=4'b0101 -> cycle 1: gnt=0001, sel=0; done -> next cycle gnt=0100, sel=2.
REQ-032 req=4'b1111 held, done every 3 cycles -> grants 0,1,2,3,0 in order, busy continuously 1.
REQ-033 Granted channel 1, req drops to 0000 before done -> gnt holds 0010 until done, then IDLE with sel=1 retained.
REQ-034 Only channel 3 requests, done pulsed -> one IDLE cycle (busy=0), then gnt=1000 again.
REQ-035 TIMEOUT_EN, TIMEOUT=4, no done -> after 4 GRANT cycles timeout=1 for 1 cycle, grant moves to the next requester; without the macro, the grant is held for 100 cycles.
REQ-036 reset_n asserted low mid-GRANT between edges -> gnt=0 and busy=0 immediately; after release, channel 0 is favoured.
